// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the five-stage pipeline hazard controller.
package pipe_ctrl_pkg;

    // Register-specifier width carried by the shadow stages (MIPS: 32 registers).
    localparam int SHADOW_REG_W = 5;

    // Memory-wait state machine.
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        MWAIT = 2'b01,
        ERR   = 2'b10
    } mem_state_e;

    // EX-operand forwarding selects.
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Shadow of the instruction sitting in EX.
    typedef struct packed {
        logic [SHADOW_REG_W-1:0] rs;
        logic [SHADOW_REG_W-1:0] rt;
        logic [SHADOW_REG_W-1:0] rd;
        logic                    regwrite;
        logic                    memread;
    } ex_shadow_t;

    // Shadow of the instruction sitting in MEM or WB (only the write-back info matters).
    typedef struct packed {
        logic [SHADOW_REG_W-1:0] rd;
        logic                    regwrite;
    } wr_shadow_t;

    localparam ex_shadow_t EX_BUBBLE = '{
        rs:       {SHADOW_REG_W{1'b0}},
        rt:       {SHADOW_REG_W{1'b0}},
        rd:       {SHADOW_REG_W{1'b0}},
        regwrite: 1'b0,
        memread:  1'b0
    };

    localparam wr_shadow_t WR_BUBBLE = '{
        rd:       {SHADOW_REG_W{1'b0}},
        regwrite: 1'b0
    };

    // A producer is a forwarding candidate only if it really writes a register other than r0.
    function automatic logic rd_live(input logic [SHADOW_REG_W-1:0] rd, input logic regwrite);
        return regwrite && (rd != {SHADOW_REG_W{1'b0}});
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Forwarding-select for one EX operand: MEM producer beats WB producer beats register file.
module fwd_select
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = SHADOW_REG_W
) (
    input  logic [REG_W-1:0] i_op,
    input  logic [REG_W-1:0] i_mem_rd,
    input  logic             i_mem_regwrite,
    input  logic [REG_W-1:0] i_wb_rd,
    input  logic             i_wb_regwrite,
    output logic [1:0]       o_sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = rd_live(i_mem_rd, i_mem_regwrite) && (i_mem_rd == i_op);
    assign w_wb_hit  = rd_live(i_wb_rd, i_wb_regwrite) && (i_wb_rd == i_op);

    // Priority select: the younger (MEM) result is the architecturally correct one.
    always_comb begin
        o_sel = FWD_REG;
        if (w_mem_hit) begin
            o_sel = FWD_MEM;
        end else if (w_wb_hit) begin
            o_sel = FWD_WB;
        end else begin
            o_sel = FWD_REG;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall / flush / forward controller for the five-stage MIPS pipeline.
// Tracks destination info of EX/MEM/WB in shadow registers and freezes the
// whole pipeline while a data-memory access waits for dmem_ready.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W       = SHADOW_REG_W,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_wr_reg,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             mem_pcsrc,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             pipe_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int                WCNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    // Shadow stages and FSM state.
    ex_shadow_t        r_ex;
    wr_shadow_t        r_mem;
    wr_shadow_t        r_wb;
    mem_state_e        r_state;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic              r_mem_err;
    logic [CNT_W-1:0]  r_stall_cycles;
    logic [CNT_W-1:0]  r_flush_events;

    // Combinational decisions.
    ex_shadow_t w_id_fields;
    wr_shadow_t w_ex_fields;
    logic       w_freeze;
    logic       w_hazard;
    logic       w_branch;
    logic       w_load_use;

    assign w_id_fields = '{
        rs:       id_rs,
        rt:       id_rt,
        rd:       id_wr_reg,
        regwrite: id_regwrite,
        memread:  id_memread
    };

    assign w_ex_fields = '{
        rd:       r_ex.rd,
        regwrite: r_ex.regwrite
    };

    // Freeze whenever an outstanding data-memory access has not completed, or after a timeout.
    always_comb begin
        w_freeze = 1'b0;
        case (r_state)
            RUN:     w_freeze = mem_access && !dmem_ready;
            MWAIT:   w_freeze = !dmem_ready;
            ERR:     w_freeze = 1'b1;
            default: w_freeze = 1'b1;
        endcase
    end

    // A load in EX whose destination is read by the instruction in decode.
    assign w_hazard = id_valid && r_ex.memread
                      && (r_ex.rd != {SHADOW_REG_W{1'b0}})
                      && ((r_ex.rd == id_rs) || (id_uses_rt && (r_ex.rd == id_rt)));

    // Freeze beats branch, branch beats load-use (the dependent instruction is being squashed anyway).
    assign w_branch   = !w_freeze && mem_pcsrc;
    assign w_load_use = !w_freeze && !mem_pcsrc && w_hazard;

    // Pipeline enables and bubble injection for the current cycle.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        pipe_en      = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (w_freeze) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            pipe_en  = 1'b0;
        end else if (w_branch) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (w_load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
        end
    end

    fwd_select #(
        .REG_W (SHADOW_REG_W)
    ) u_fwd_a (
        .i_op           (r_ex.rs),
        .i_mem_rd       (r_mem.rd),
        .i_mem_regwrite (r_mem.regwrite),
        .i_wb_rd        (r_wb.rd),
        .i_wb_regwrite  (r_wb.regwrite),
        .o_sel          (fwd_a)
    );

    fwd_select #(
        .REG_W (SHADOW_REG_W)
    ) u_fwd_b (
        .i_op           (r_ex.rt),
        .i_mem_rd       (r_mem.rd),
        .i_mem_regwrite (r_mem.regwrite),
        .i_wb_rd        (r_wb.rd),
        .i_wb_regwrite  (r_wb.regwrite),
        .o_sel          (fwd_b)
    );

    // Shadow stages advance in lock-step with the datapath pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex  <= EX_BUBBLE;
            r_mem <= WR_BUBBLE;
            r_wb  <= WR_BUBBLE;
        end else if (pipe_en) begin
            r_ex  <= id_ex_flush ? EX_BUBBLE : w_id_fields;
            r_mem <= ex_mem_flush ? WR_BUBBLE : w_ex_fields;
            r_wb  <= r_mem;
        end
    end

    // Memory-wait FSM: counts wait cycles and latches a sticky error on timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_wait_cnt <= {WCNT_W{1'b0}};
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (mem_access && !dmem_ready) begin
                        r_state    <= MWAIT;
                        r_wait_cnt <= {WCNT_W{1'b0}};
                    end
                end
                MWAIT: begin
                    r_wait_cnt <= r_wait_cnt + WCNT_ONE;
                    if (dmem_ready) begin
                        r_state <= RUN;
                    end else if (r_wait_cnt == WCNT_LAST) begin
                        r_state   <= ERR;
                        r_mem_err <= 1'b1;
                    end
                end
                ERR: begin
                    r_state   <= ERR;
                    r_mem_err <= 1'b1;
                end
                default: begin
                    r_state    <= RUN;
                    r_wait_cnt <= {WCNT_W{1'b0}};
                end
            endcase
        end
    end

    // Saturating performance counters for lost cycles and branch flushes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= {CNT_W{1'b0}};
            r_flush_events <= {CNT_W{1'b0}};
        end else begin
            if ((w_freeze || w_load_use) && (r_stall_cycles != CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + CNT_ONE;
            end
            if (w_branch && (r_flush_events != CNT_MAX)) begin
                r_flush_events <= r_flush_events + CNT_ONE;
            end
        end
    end

    assign mem_err      = r_mem_err;
    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=4, 4-bit counters to reach saturation).
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_wr_reg;
    logic       id_uses_rt, id_regwrite, id_memread;
    logic       mem_pcsrc, mem_access, dmem_ready;
    logic       pc_en, if_id_en, pipe_en;
    logic       if_id_flush, id_ex_flush, ex_mem_flush;
    logic [1:0] fwd_a, fwd_b;
    logic       mem_err;
    logic [3:0] stall_cycles, flush_events;

    int n_checks = 0;
    int n_fail   = 0;

    logic [18:0] exp_q[$];
    string       name_q[$];

    pipe_hazard_ctrl #(
        .REG_W       (5),
        .MEM_TIMEOUT (4),
        .CNT_W       (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .id_wr_reg    (id_wr_reg),
        .id_regwrite  (id_regwrite),
        .id_memread   (id_memread),
        .mem_pcsrc    (mem_pcsrc),
        .mem_access   (mem_access),
        .dmem_ready   (dmem_ready),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .pipe_en      (pipe_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .mem_err      (mem_err),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic ur, input logic [4:0] wr, input logic rw, input logic mr);
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_uses_rt  = ur;
        id_wr_reg   = wr;
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    // en = {pc_en, if_id_en, pipe_en}; fl = {if_id, id_ex, ex_mem} flush
    task automatic push(input string nm, input logic [2:0] en, input logic [2:0] fl,
                        input logic [1:0] fa, input logic [1:0] fb, input logic err,
                        input logic [3:0] st, input logic [3:0] fe);
        exp_q.push_back({en, fl, fa, fb, err, st, fe});
        name_q.push_back(nm);
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the updating edge.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                logic [18:0] e;
                logic [18:0] a;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush, ex_mem_flush,
                      fwd_a, fwd_b, mem_err, stall_cycles, flush_events};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s: got en=%b fl=%b fa=%b fb=%b err=%b st=%0d fe=%0d, want en=%b fl=%b fa=%b fb=%b err=%b st=%0d fe=%0d",
                             nm, a[18:16], a[15:13], a[12:11], a[10:9], a[8], a[7:4], a[3:0],
                             e[18:16], e[15:13], e[12:11], e[10:9], e[8], e[7:4], e[3:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus: one expectation per cycle, computed by hand from the pipeline rules.
    initial begin
        reset = 1'b1;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        mem_pcsrc  = 1'b0;
        mem_access = 1'b0;
        dmem_ready = 1'b0;
        tick;
        push("reset_state", 3'b111, 3'b000, 2'b00, 2'b00, 1'b0, 4'd0, 4'd0);

        // Load-use: lw r8 enters EX, then add r9,r8,r4 in decode.
        tick; reset = 1'b0;
        set_id(1'b1, 5'd2, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1);
        push("lw_issue", 3'b111, 3'b000, 2'b00, 2'b00, 1'b0, 4'd0, 4'd0);
        tick; set_id(1'b1, 5'd8, 5'd4, 1'b1, 5'd9, 1'b1, 1'b0);
        push("lu_stall", 3'b001, 3'b010, 2'b00, 2'b00, 1'b0, 4'd0, 4'd0);
        tick;
        push("lu_bubble", 3'b111, 3'b000, 2'b00, 2'b00, 1'b0, 4'd1, 4'd0);
        tick; set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        push("lu_fwd_wb", 3'b111, 3'b000, 2'b01, 2'b00, 1'b0, 4'd1, 4'd0);

        // Forward priority: two writers of r5, then a reader of rt=5.
        tick; set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        push("prio_issue_a", 3'b111, 3'b000, 2'b00, 2'b00, 1'b0, 4'd1, 4'd0);
        tick; set_id(1'b1, 5'd3, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0);
        push("prio_issue_b", 3'b111, 3'b000, 2'b00, 2'b00, 1'b0, 4'd1, 4'd0);
        tick; set_id(1'b1, 5'd6, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);
        push("prio_issue_c", 3'b111, 3'b000, 2'b00, 2'b00, 1'b0, 4'd1, 4'd0);
        tick; set_id(1'b1, 5'd1, 5'd1, 1'b1, 5'd0, 1'b1, 1'b0);
        push("fwd_mem_prio", 3'b111, 3'b000, 2'b00, 2'b10, 1'b0, 4'd1, 4'd0);

        // Same shape with r0 as destination: never forwarded.
        tick; set_id(1'b1, 5'd2, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
        push("r0_issue_f", 3'b111, 3'b000, 2'b00, 2'b00, 1'b0, 4'd1, 4'd0);
        tick; set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0);
        push("r0_issue_g", 3'b111, 3'b000, 2'b00, 2'b00, 1'b0, 4'd1, 4'd0);

        // Branch taken in the cycle the r0 reader sits in EX.
        tick; set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); mem_pcsrc = 1'b1;
        push("r0_nofwd_branch", 3'b111, 3'b111, 2'b00, 2'b00, 1'b0, 4'd1, 4'd0);
        tick; mem_pcsrc = 1'b0; set_id(1'b1, 5'd2, 5'd10, 1'b0, 5'd10, 1'b1, 1'b1);
        push("branch_counted", 3'b111, 3'b000, 2'b00, 2'b00, 1'b0, 4'd1, 4'd1);
        tick; mem_pcsrc = 1'b1; set_id(1'b1, 5'd10, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
        push("branch_over_lu", 3'b111, 3'b111, 2'b00, 2'b00, 1'b0, 4'd1, 4'd1);
        tick; mem_pcsrc = 1'b0; set_id(1'b1, 5'd1, 5'd12, 1'b0, 5'd12, 1'b1, 1'b1);
        push("after_branch", 3'b111, 3'b000, 2'b00, 2'b00, 1'b0, 4'd1, 4'd2);
        tick; set_id(1'b1, 5'd3, 5'd12, 1'b0, 5'd13, 1'b1, 1'b0);
        push("rt_unused_nostall", 3'b111, 3'b000, 2'b00, 2'b00, 1'b0, 4'd1, 4'd2);

        // Memory wait: ready low for three cycles, high on the fourth.
        tick; set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        mem_access = 1'b1; dmem_ready = 1'b0;
        push("mwait_1", 3'b000, 3'b000, 2'b00, 2'b10, 1'b0, 4'd1, 4'd2);
        tick;
        push("mwait_2", 3'b000, 3'b000, 2'b00, 2'b10, 1'b0, 4'd2, 4'd2);
        tick;
        push("mwait_3", 3'b000, 3'b000, 2'b00, 2'b10, 1'b0, 4'd3, 4'd2);
        tick; dmem_ready = 1'b1;
        push("mwait_release", 3'b111, 3'b000, 2'b00, 2'b10, 1'b0, 4'd4, 4'd2);
        tick; mem_access = 1'b0; dmem_ready = 1'b0;
        push("run_again", 3'b111, 3'b000, 2'b00, 2'b00, 1'b0, 4'd4, 4'd2);

        // Timeout: ready never comes, four MWAIT cycles then ERR.
        tick; mem_access = 1'b1;
        push("timeout_enter", 3'b000, 3'b000, 2'b00, 2'b00, 1'b0, 4'd4, 4'd2);
        for (int k = 0; k < 4; k++) begin
            tick;
            push("timeout_wait", 3'b000, 3'b000, 2'b00, 2'b00, 1'b0, 4'(5 + k), 4'd2);
        end
        for (int k = 0; k < 9; k++) begin
            tick;
            mem_access = 1'b0; dmem_ready = 1'b1; mem_pcsrc = 1'b1;
            push("err_hold_sat", 3'b000, 3'b000, 2'b00, 2'b00, 1'b1,
                 ((9 + k) > 15) ? 4'd15 : 4'(9 + k), 4'd2);
        end

        // Asynchronous reset in ERR: checked before the next rising edge.
        tick; reset = 1'b1; mem_access = 1'b0; dmem_ready = 1'b0; mem_pcsrc = 1'b0;
        push("async_reset_err", 3'b111, 3'b000, 2'b00, 2'b00, 1'b0, 4'd0, 4'd0);
        tick; reset = 1'b0;
        push("after_reset", 3'b111, 3'b000, 2'b00, 2'b00, 1'b0, 4'd0, 4'd0);

        tick;
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
